// File: rtl/regfile_gen.sv
// Parametrised CPU register file: hardwired r0/r1, PC alias in the top register,
// write bypass, stallable registered reads, clear sequencer and load scoreboard.
// Optional debug print port pair enabled by defining REGFILE_DBG_EN.
module regfile_gen #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 5,
    parameter int NREAD            = 2,
    parameter int MICROOPS_ENABLED = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         PC,
    input  logic [NREAD*ADDR_W-1:0]   raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      hold,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      we,
    input  logic                      lock_en,
    input  logic [ADDR_W-1:0]         lock_addr,
    input  logic                      clr_req,
`ifdef REGFILE_DBG_EN
    input  logic [ADDR_W-1:0]         dbgreg,
    input  logic                      dbgreg_en,
`endif
    output logic                      ready
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP   = ADDR_W'(DEPTH-1);
    localparam logic [DATA_W-1:0] DELTA = (MICROOPS_ENABLED != 0) ? DATA_W'(1) : DATA_W'(2);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]              state;
    logic [ADDR_W-1:0]       ptr;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]        pending;
    logic [NREAD*DATA_W-1:0] rdata_nxt;
    logic [NREAD-1:0]        rbusy_nxt;
    logic                    wr_ok;
    logic                    lk_ok;

    function automatic logic is_special(input logic [ADDR_W-1:0] a);
        return (a == '0) || (a == ADDR_W'(1)) || (a == TOP);
    endfunction

    assign ready = (state == ST_IDLE);
    assign wr_ok = (state == ST_IDLE) && we && !is_special(waddr);
    assign lk_ok = (state == ST_IDLE) && lock_en && !is_special(lock_addr);

    always_comb begin
        rdata_nxt = '0;
        rbusy_nxt = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            if (raddr[i*ADDR_W +: ADDR_W] == '0) begin
                rdata_nxt[i*DATA_W +: DATA_W] = '0;
            end else if (raddr[i*ADDR_W +: ADDR_W] == ADDR_W'(1)) begin
                rdata_nxt[i*DATA_W +: DATA_W] = DATA_W'(1);
            end else if (raddr[i*ADDR_W +: ADDR_W] == TOP) begin
                rdata_nxt[i*DATA_W +: DATA_W] = PC + DELTA;
            end else if (we && (waddr == raddr[i*ADDR_W +: ADDR_W])) begin
                rdata_nxt[i*DATA_W +: DATA_W] = wdata;
            end else begin
                rdata_nxt[i*DATA_W +: DATA_W] = mem[raddr[i*ADDR_W +: ADDR_W]];
            end
            // A same-cycle lock on the written register keeps the old pending view.
            if (is_special(raddr[i*ADDR_W +: ADDR_W])) begin
                rbusy_nxt[i] = 1'b0;
            end else if (we && (waddr == raddr[i*ADDR_W +: ADDR_W]) &&
                         !(lock_en && (lock_addr == raddr[i*ADDR_W +: ADDR_W]))) begin
                rbusy_nxt[i] = 1'b0;
            end else begin
                rbusy_nxt[i] = pending[raddr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            ptr     <= '0;
            pending <= '0;
            rdata   <= '0;
            rbusy   <= '0;
        end else if (state == ST_CLEAR) begin
            rdata   <= '0;
            rbusy   <= '0;
            pending <= '0;
            ptr     <= ptr + ADDR_W'(1);
            if (ptr == TOP) state <= ST_IDLE;
        end else begin
            if (!hold) begin
                rdata <= rdata_nxt;
                rbusy <= rbusy_nxt;
            end
            if (clr_req) begin
                state   <= ST_CLEAR;
                ptr     <= '0;
                pending <= '0;
            end else begin
                if (wr_ok) pending[waddr]     <= 1'b0;
                if (lk_ok) pending[lock_addr] <= 1'b1;
            end
        end
    end

    // Storage has no reset; the clear sequencer zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) mem[ptr] <= '0;
        else if (wr_ok)        mem[waddr] <= wdata;
    end

`ifdef REGFILE_DBG_EN
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (dbgreg_en) $write("[R%0d=%0d]", dbgreg, mem[dbgreg]);
    end
`endif
`endif

endmodule

// File: tb/tb_regfile_gen.sv
// Self-checking bench for regfile_gen: directed scenarios plus random traffic
// against an array-based behavioural model (two instances cover both PC offsets).
module tb_regfile_gen;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   PC = '0;
    logic [NR*AW-1:0] raddr = '0;
    logic [NR*DW-1:0] rdata, rdata2;
    logic [NR-1:0]   rbusy, rbusy2;
    logic            hold = 1'b0;
    logic [AW-1:0]   waddr = '0;
    logic [DW-1:0]   wdata = '0;
    logic            we = 1'b0;
    logic            lock_en = 1'b0;
    logic [AW-1:0]   lock_addr = '0;
    logic            clr_req = 1'b0;
    logic            ready, ready2;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    logic [DW-1:0]    m_mem [DEPTH];
    bit               m_pend [DEPTH];
    bit               m_clearing;
    int               m_left;
    logic [NR*DW-1:0] m_rdata, m_rdata2;
    logic [NR-1:0]    m_rbusy;

    always #5 clk = ~clk;

    regfile_gen #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .MICROOPS_ENABLED(1)) dut (
        .clk(clk), .rst(rst), .PC(PC), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .hold(hold), .waddr(waddr), .wdata(wdata), .we(we), .lock_en(lock_en),
        .lock_addr(lock_addr), .clr_req(clr_req), .ready(ready));

    regfile_gen #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .MICROOPS_ENABLED(0)) dut2 (
        .clk(clk), .rst(rst), .PC(PC), .raddr(raddr), .rdata(rdata2), .rbusy(rbusy2),
        .hold(hold), .waddr(waddr), .wdata(wdata), .we(we), .lock_en(lock_en),
        .lock_addr(lock_addr), .clr_req(clr_req), .ready(ready2));

    function automatic bit special(input int unsigned a);
        return a == 0 || a == 1 || a == DEPTH-1;
    endfunction

    task automatic model_reset();
        m_clearing = 1;
        m_left     = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 0;
        m_rdata  = '0;
        m_rdata2 = '0;
        m_rbusy  = '0;
    endtask

    task automatic quiet_inputs();
        we = 0; lock_en = 0; clr_req = 0; hold = 0;
        waddr = '0; wdata = '0; lock_addr = '0; raddr = '0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUTs.
    task automatic tick();
        int unsigned a, wa, la;
        logic [DW-1:0] v, v2;
        bit b;
        logic [NR*DW-1:0] nr, nr2;
        logic [NR-1:0] nb;
        wa = waddr; la = lock_addr;
        nr = '0; nr2 = '0; nb = '0;
        for (int i = 0; i < NR; i++) begin
            a = raddr[i*AW +: AW];
            if (a == 0)                   begin v = 0; v2 = 0; end
            else if (a == 1)              begin v = 1; v2 = 1; end
            else if (a == DEPTH-1)        begin v = PC + 32'd1; v2 = PC + 32'd2; end
            else if (we && wa == a)       begin v = wdata; v2 = wdata; end
            else                          begin v = m_mem[a]; v2 = m_mem[a]; end
            if (special(a))                                  b = 0;
            else if (we && wa == a && !(lock_en && la == a)) b = 0;
            else                                             b = m_pend[a];
            nr[i*DW +: DW] = v; nr2[i*DW +: DW] = v2; nb[i] = b;
        end
        if (m_clearing) begin
            m_rdata = '0; m_rdata2 = '0; m_rbusy = '0;
            m_mem[DEPTH - m_left] = '0;
            m_left--;
            if (m_left == 0) m_clearing = 0;
        end else begin
            if (!hold) begin m_rdata = nr; m_rdata2 = nr2; m_rbusy = nb; end
            if (we && !special(wa)) begin m_mem[wa] = wdata; m_pend[wa] = 0; end
            if (lock_en && !special(la)) m_pend[la] = 1;
            if (clr_req) begin
                m_clearing = 1; m_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_pend[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0; quiet_inputs(); model_reset();
        #2;
        n_checks++;
        if (rdata !== '0 || rbusy !== '0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got rdata=%h rbusy=%b ready=%b want 0/0/0", rdata, rbusy, ready);
        end
        rst = 1;
        for (int k = 0; k < 10; k++) tick();
        // reset again mid-clear: the whole DEPTH-cycle sequence must restart
        rst = 0; model_reset();
        #2;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_midclear got ready=%b want 0", ready);
        end
        rst = 1;
        raddr = {5'd31, 5'd1};
        PC = 32'h40;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            n_checks++;
            if (ready !== (k == DEPTH) || ready2 !== (k == DEPTH)) begin
                n_fail++; $display("FAIL clear_ready cycle %0d got %b want %b", k, ready, k == DEPTH);
            end
            n_checks++;
            if (rdata !== '0 || rbusy !== '0) begin
                n_fail++; $display("FAIL clear_rdata cycle %0d got %h want 0", k, rdata);
            end
        end
        raddr = {5'd5, 5'd5};
        tick();
        n_checks++;
        if (rdata !== '0 || rbusy !== '0) begin
            n_fail++; $display("FAIL read_r5_after_clear got %h want 0", rdata);
        end
    endtask

    task automatic test_pc_alias();
        quiet_inputs();
        PC = 32'h100; raddr = {5'd1, 5'd31};
        tick();
        n_checks++;
        if (rdata !== {32'd1, 32'h101}) begin
            n_fail++; $display("FAIL pc_alias_d1 got %h want %h", rdata, {32'd1, 32'h101});
        end
        n_checks++;
        if (rdata2 !== {32'd1, 32'h102}) begin
            n_fail++; $display("FAIL pc_alias_d2 got %h want %h", rdata2, {32'd1, 32'h102});
        end
        PC = 32'hFFFF_FFFF; raddr = {5'd0, 5'd31};
        tick();
        n_checks++;
        if (rdata[31:0] !== 32'h0 || rdata2[31:0] !== 32'h1) begin
            n_fail++; $display("FAIL pc_wrap got %h/%h want 0/1", rdata[31:0], rdata2[31:0]);
        end
    endtask

    task automatic test_bypass();
        quiet_inputs();
        we = 1; waddr = 7; wdata = 32'hDEAD; raddr = {5'd7, 5'd7};
        tick();
        n_checks++;
        if (rdata !== {32'hDEAD, 32'hDEAD}) begin
            n_fail++; $display("FAIL bypass got %h want %h", rdata, {32'hDEAD, 32'hDEAD});
        end
        we = 0;
        tick();
        n_checks++;
        if (rdata[31:0] !== 32'hDEAD) begin
            n_fail++; $display("FAIL stored_r7 got %h want dead", rdata[31:0]);
        end
        we = 1; waddr = 0; wdata = 5; raddr = {5'd0, 5'd0};
        tick();
        we = 0;
        tick();
        n_checks++;
        if (rdata !== '0) begin
            n_fail++; $display("FAIL write_r0 got %h want 0", rdata);
        end
    endtask

    task automatic test_scoreboard();
        quiet_inputs();
        lock_en = 1; lock_addr = 9;
        tick();
        lock_en = 0; raddr = {5'd2, 5'd9};
        tick();
        n_checks++;
        if (rbusy !== 2'b01) begin
            n_fail++; $display("FAIL lock_busy got %b want 01", rbusy);
        end
        we = 1; waddr = 9; wdata = 3;
        tick();
        n_checks++;
        if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'd3) begin
            n_fail++; $display("FAIL write_unlock got %b/%h want 0/3", rbusy[0], rdata[31:0]);
        end
        wdata = 4; lock_en = 1; lock_addr = 9;
        tick();
        we = 0; lock_en = 0;
        tick();
        n_checks++;
        if (rbusy[0] !== 1'b1 || rdata[31:0] !== 32'd4) begin
            n_fail++; $display("FAIL lock_wins got %b/%h want 1/4", rbusy[0], rdata[31:0]);
        end
    endtask

    task automatic test_hold();
        quiet_inputs();
        we = 1; waddr = 4; wdata = 32'h11; raddr = {5'd0, 5'd4};
        tick();
        hold = 1; wdata = 32'h22;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (rdata[31:0] !== 32'h11) begin
                n_fail++; $display("FAIL hold cycle %0d got %h want 11", k, rdata[31:0]);
            end
        end
        hold = 0; we = 0;
        tick();
        n_checks++;
        if (rdata[31:0] !== 32'h22) begin
            n_fail++; $display("FAIL hold_release got %h want 22", rdata[31:0]);
        end
    endtask

    task automatic test_clear();
        quiet_inputs();
        we = 1; waddr = 3; wdata = 32'h55; lock_en = 1; lock_addr = 3;
        tick();
        we = 0; lock_en = 0; clr_req = 1;
        tick();
        clr_req = 0; we = 1; waddr = 3; wdata = 32'h77; raddr = {5'd3, 5'd3};
        for (int k = 1; k <= DEPTH; k++) begin
            n_checks++;
            if (ready !== 1'b0 || rdata !== '0) begin
                n_fail++; $display("FAIL req_clear cycle %0d got ready=%b rdata=%h want 0/0", k, ready, rdata);
            end
            tick();
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL req_clear_done got ready=%b want 1", ready);
        end
        we = 0;
        tick();
        n_checks++;
        if (rdata !== '0 || rbusy !== '0) begin
            n_fail++; $display("FAIL r3_cleared got %h/%b want 0/0", rdata, rbusy);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            PC        = $urandom;
            raddr     = NR*AW'($urandom);
            we        = ($urandom_range(0, 1) == 1);
            waddr     = AW'($urandom_range(0, 15));
            wdata     = $urandom;
            lock_en   = ($urandom_range(0, 3) == 0);
            lock_addr = AW'($urandom_range(0, 15));
            hold      = ($urandom_range(0, 3) == 0);
            clr_req   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 1) == 1) raddr[AW +: AW] = raddr[0 +: AW];
            if ($urandom_range(0, 1) == 1) raddr[0 +: AW] = waddr;
            tick();
            n_checks++;
            if (rdata !== m_rdata || rbusy !== m_rbusy || ready !== !m_clearing) begin
                n_fail++;
                $display("FAIL random cycle %0d got %h/%b/%b want %h/%b/%b",
                         k, rdata, rbusy, ready, m_rdata, m_rbusy, !m_clearing);
            end
            n_checks++;
            if (rdata2 !== m_rdata2 || rbusy2 !== m_rbusy) begin
                n_fail++;
                $display("FAIL random_d2 cycle %0d got %h/%b want %h/%b", k, rdata2, rbusy2, m_rdata2, m_rbusy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        test_reset();
        test_pc_alias();
        test_bypass();
        test_scoreboard();
        test_hold();
        test_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
